char_jump_ctrl: RTL and testbench

Vertical-motion controller for the SkyHop character. It runs on the 40 MHz system clock and advances only on `movement_tick` strobes from the movement timer. A jump/rise/fall/land state machine sequences the character's Y position with discrete gravity. It hands `char_y` and status flags to the drawing and collision logic.

---
 rtl/char_jump_ctrl.sv | 118 +++++++++++
 tb/tb_char_jump_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/char_jump_ctrl.sv
// char_jump_ctrl: SkyHop vertical motion (IDLE/RISE/FALL/LAND/DEAD) with tick-gated discrete gravity.
// Optional macro JUMP_CUT_EN: releasing jump while rising caps upward speed at 2 (variable jump height).
module char_jump_ctrl #(
    parameter logic [9:0] Y_START      = 10'd500,
    parameter logic [9:0] Y_FLOOR      = 10'd599,
    parameter logic [5:0] JUMP_VEL     = 6'd12,
    parameter logic [5:0] MAX_FALL_VEL = 6'd10,
    parameter logic [7:0] GRAV_TICKS   = 8'd20
) (
    input  logic       clk_40MHz,
    input  logic       rst_n,
    input  logic       movement_tick,
    input  logic       jump_req,
    input  logic       on_platform,
    input  logic [9:0] platform_y,
    output logic [9:0] char_y,
    output logic [2:0] char_state,
    output logic       landed,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RISE = 3'd1,
        FALL = 3'd2,
        LAND = 3'd3,
        DEAD = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  vel;
    logic [7:0]  grav_cnt;

    logic        grav_event;
    logic [7:0]  grav_cnt_next;
    logic [10:0] y_up;
    logic [10:0] y_down;
    logic [9:0]  rise_y;
    logic [5:0]  rise_vel;
    logic [5:0]  fall_vel;
    logic        floor_hit;

    // Next-value arithmetic is done at 11 bits so rising clamps at 0 and falling never wraps.
    always_comb begin
        grav_event    = (grav_cnt == (GRAV_TICKS - 8'd1));
        grav_cnt_next = grav_event ? 8'd0 : (grav_cnt + 8'd1);
        y_up          = {1'b0, char_y} - {5'b0, vel};
        y_down        = {1'b0, char_y} + {5'b0, vel};
        rise_y        = y_up[10] ? 10'd0 : y_up[9:0];
        rise_vel      = vel - {5'b0, grav_event};
`ifdef JUMP_CUT_EN
        if (!jump_req && (rise_vel > 6'd2)) begin
            rise_vel = 6'd2;
        end
`endif
        fall_vel      = vel;
        if (grav_event && (vel < MAX_FALL_VEL)) begin
            fall_vel = vel + 6'd1;
        end
        floor_hit     = (y_down >= {1'b0, Y_FLOOR});
    end

    // LAND always drops back to IDLE after one clock; everything else waits for a movement tick.
    always_ff @(posedge clk_40MHz) begin
        if (!rst_n) begin
            state     <= IDLE;
            char_y    <= Y_START;
            vel       <= 6'd0;
            grav_cnt  <= 8'd0;
            landed    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (state == LAND) begin
                state <= IDLE;
            end else if (movement_tick) begin
                case (state)
                    IDLE: begin
                        if (jump_req) begin
                            state    <= RISE;
                            vel      <= JUMP_VEL;
                            grav_cnt <= 8'd0;
                        end
                    end
                    RISE: begin
                        char_y   <= rise_y;
                        vel      <= rise_vel;
                        grav_cnt <= grav_cnt_next;
                        if (rise_vel == 6'd0) begin
                            state <= FALL;
                        end
                    end
                    FALL: begin
                        if (on_platform) begin
                            char_y <= platform_y;
                            vel    <= 6'd0;
                            state  <= LAND;
                            landed <= 1'b1;
                        end else if (floor_hit) begin
                            char_y    <= Y_FLOOR;
                            state     <= DEAD;
                            game_over <= 1'b1;
                        end else begin
                            char_y   <= y_down[9:0];
                            vel      <= fall_vel;
                            grav_cnt <= grav_cnt_next;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign char_state = state;

endmodule

// File: tb/tb_char_jump_ctrl.sv
// tb_char_jump_ctrl: vector table, directed corner sequences and randomized run against a behavioural model.
// Two instances (GRAV_TICKS=1 and 3) share stimulus; honours JUMP_CUT_EN when defined.
module tb_char_jump_ctrl;

    logic       clk_40MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       movement_tick = 1'b0;
    logic       jump_req = 1'b0;
    logic       on_platform = 1'b0;
    logic [9:0] platform_y = 10'd0;

    logic [9:0] y_a, y_b;
    logic [2:0] st_a, st_b;
    logic       landed_a, landed_b, go_a, go_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int y;
        int st;
        int vel;
        int cnt;
        bit landed;
    } mstate_t;

    typedef struct {
        bit tick;
        bit jump;
        bit onp;
        int py;
        int exp_y;
        int exp_st;
        bit exp_landed;
    } vec_t;

    mstate_t ma, mb;
    vec_t    vecs[$];

    char_jump_ctrl #(.GRAV_TICKS(8'd1)) dut_a (
        .clk_40MHz(clk_40MHz), .rst_n(rst_n), .movement_tick(movement_tick),
        .jump_req(jump_req), .on_platform(on_platform), .platform_y(platform_y),
        .char_y(y_a), .char_state(st_a), .landed(landed_a), .game_over(go_a)
    );

    char_jump_ctrl #(.GRAV_TICKS(8'd3)) dut_b (
        .clk_40MHz(clk_40MHz), .rst_n(rst_n), .movement_tick(movement_tick),
        .jump_req(jump_req), .on_platform(on_platform), .platform_y(platform_y),
        .char_y(y_b), .char_state(st_b), .landed(landed_b), .game_over(go_b)
    );

    always #5 clk_40MHz = ~clk_40MHz;

    // Reference behaviour: one clock of the character, from the written motion rules.
    function automatic mstate_t model_step(mstate_t s, bit rn, bit tk, bit jp, bit op, int py, int gt);
        mstate_t n = s;
        bit grav;
        n.landed = 1'b0;
        if (!rn) begin
            n.y = 500; n.st = 0; n.vel = 0; n.cnt = 0;
            return n;
        end
        if (s.st == 3) begin
            n.st = 0;
            return n;
        end
        if (!tk || s.st == 4) return n;
        grav = (s.cnt == gt - 1);
        if (s.st == 0) begin
            if (jp) begin
                n.st = 1; n.vel = 12; n.cnt = 0;
            end
        end else if (s.st == 1) begin
            n.cnt = grav ? 0 : s.cnt + 1;
            n.y = (s.y > s.vel) ? s.y - s.vel : 0;
            n.vel = grav ? s.vel - 1 : s.vel;
`ifdef JUMP_CUT_EN
            if (!jp && n.vel > 2) n.vel = 2;
`endif
            if (n.vel == 0) n.st = 2;
        end else begin
            if (op) begin
                n.y = py; n.vel = 0; n.st = 3; n.landed = 1'b1;
            end else if (s.y + s.vel >= 599) begin
                n.y = 599; n.st = 4;
            end else begin
                n.y = s.y + s.vel;
                n.cnt = grav ? 0 : s.cnt + 1;
                if (grav && s.vel < 10) n.vel = s.vel + 1;
            end
        end
        return n;
    endfunction

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        check_val("a_y", {22'd0, y_a}, ma.y);
        check_val("a_state", {29'd0, st_a}, ma.st);
        check_val("a_landed", {31'd0, landed_a}, {31'd0, ma.landed});
        check_val("a_game_over", {31'd0, go_a}, (ma.st == 4) ? 1 : 0);
        check_val("b_y", {22'd0, y_b}, mb.y);
        check_val("b_state", {29'd0, st_b}, mb.st);
        check_val("b_landed", {31'd0, landed_b}, {31'd0, mb.landed});
        check_val("b_game_over", {31'd0, go_b}, (mb.st == 4) ? 1 : 0);
    endtask

    task automatic apply_stimulus(bit rn, bit tk, bit jp, bit op, logic [9:0] py);
        @(negedge clk_40MHz);
        rst_n = rn;
        movement_tick = tk;
        jump_req = jp;
        on_platform = op;
        platform_y = py;
        ma = model_step(ma, rn, tk, jp, op, int'(py), 1);
        mb = model_step(mb, rn, tk, jp, op, int'(py), 3);
        @(posedge clk_40MHz);
        #1;
        check_output();
    endtask

    initial begin
        int rise_y[12] = '{488, 477, 467, 458, 450, 443, 437, 432, 428, 425, 423, 422};
        bit rn, dead;
        ma = '{0, 0, 0, 0, 1'b0};
        mb = '{0, 0, 0, 0, 1'b0};

        // Full jump with GRAV_TICKS=1 on dut_a, then a platform landing and an auto-bounce.
        vecs.push_back('{1, 1, 0, 0, 500, 1, 0});
        vecs.push_back('{1, 1, 0, 0, rise_y[0], 1, 0});
        vecs.push_back('{0, 1, 0, 0, rise_y[0], 1, 0});
        for (int i = 1; i < 12; i++) vecs.push_back('{1, 1, 1, 100, rise_y[i], (i == 11) ? 2 : 1, 0});
        vecs.push_back('{1, 1, 0, 0, 422, 2, 0});
        vecs.push_back('{1, 0, 0, 0, 423, 2, 0});
        vecs.push_back('{1, 0, 0, 0, 425, 2, 0});
        vecs.push_back('{0, 0, 1, 300, 425, 2, 0});
        vecs.push_back('{1, 1, 1, 450, 450, 3, 1});
        vecs.push_back('{1, 1, 0, 0, 450, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 450, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 450, 1, 0});

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        check_val("reset_y", {22'd0, y_a}, 500);
        check_val("reset_state", {29'd0, st_a}, 0);
        check_val("reset_landed", {31'd0, landed_a}, 0);
        check_val("reset_game_over", {31'd0, go_a}, 0);

        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].tick, vecs[i].jump, vecs[i].onp, vecs[i].py[9:0]);
            check_val($sformatf("vec%0d_y", i), {22'd0, y_a}, vecs[i].exp_y);
            check_val($sformatf("vec%0d_state", i), {29'd0, st_a}, vecs[i].exp_st);
            check_val($sformatf("vec%0d_landed", i), {31'd0, landed_a}, {31'd0, vecs[i].exp_landed});
            check_val($sformatf("vec%0d_game_over", i), {31'd0, go_a}, (vecs[i].exp_st == 4) ? 1 : 0);
        end

        // Floor: keep ticking without platforms until dut_a dies, then it must stay frozen.
        dead = 1'b0;
        for (int i = 0; i < 400 && !dead; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
            dead = (st_a == 3'd4);
        end
        check_val("floor_reached", {31'd0, dead}, 1);
        check_val("floor_y", {22'd0, y_a}, 599);
        check_val("floor_game_over", {31'd0, go_a}, 1);
        for (int i = 0; i < 100; i++)
            apply_stimulus(1'b1, 1'b1, 1'($urandom), 1'($urandom), 10'($urandom_range(0, 1023)));
        check_val("dead_hold_y", {22'd0, y_a}, 599);
        check_val("dead_hold_state", {29'd0, st_a}, 4);

        // Tick gating: jump held for 1000 clocks with no tick leaves IDLE untouched.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        for (int i = 0; i < 1000; i++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 10'd77);
        check_val("gate_y", {22'd0, y_a}, 500);
        check_val("gate_state", {29'd0, st_a}, 0);

`ifdef JUMP_CUT_EN
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        check_val("cut_tick1_y", {22'd0, y_a}, 488);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        check_val("cut_tick2_y", {22'd0, y_a}, 477);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        check_val("cut_tick3_y", {22'd0, y_a}, 467);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        check_val("cut_tick4_y", {22'd0, y_a}, 465);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
        check_val("cut_apex_y", {22'd0, y_a}, 464);
        check_val("cut_apex_state", {29'd0, st_a}, 2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
`endif

        // Reset mid-flight beats a tick on the same edge.
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'd100);
        check_val("midflight_reset_y", {22'd0, y_a}, 500);
        check_val("midflight_reset_state", {29'd0, st_a}, 0);

        // Randomized run; both instances are checked against the model every clock.
        for (int i = 0; i < 4000; i++) begin
            rn = !(($urandom_range(0, 299) == 0) ||
                   (ma.st == 4 && mb.st == 4 && $urandom_range(0, 7) == 0));
            apply_stimulus(rn, $urandom_range(0, 1) == 0, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 7) == 0, 10'($urandom_range(0, 1023)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
